// File: rtl/spi_master_lbus_if.sv
// spi_master_lbus_if
// Request/response handshake between a local-bus host and spi_master_lbus.
//   start   : one-cycle transaction request (host -> engine)
//   rw      : 1 = read, 0 = write, sampled with start
//   address : 13-bit register address, sampled with start
//   wdata   : write byte, sampled with start
//   busy    : transaction in progress (engine -> host)
//   done    : one-cycle end-of-transaction pulse
//   rdata   : last byte read, held until the next read completes
// Modport master is the host side, modport slave is the SPI engine side.
interface spi_master_lbus_if;
   logic        start;
   logic        rw;
   logic [12:0] address;
   logic [7:0]  wdata;
   logic        busy;
   logic        done;
   logic [7:0]  rdata;

   modport master (output start, rw, address, wdata, input  busy, done, rdata);
   modport slave  (input  start, rw, address, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_master_lbus.sv
// spi_master_lbus
// Three-wire SPI master issuing 24-bit frames {rw, 2'b00, address[12:0], data[7:0]},
// MSB first, over a shared bidirectional sdio line.
// Ports:
//   clk_i      : single clock for all logic
//   rst_i      : asynchronous active-high reset
//   bus        : host handshake (start/rw/address/wdata in, busy/done/rdata out)
//   sclk_o     : SPI clock, idles low
//   ss_n_o     : chip select, active low, idles high
//   sdio_out_o : data driven toward sdio
//   sdio_in_i  : data sampled from sdio
//   sdio_oe_o  : 1 = master drives sdio, 0 = released to slave
//
// state  | meaning
// IDLE   | ss_n high, waiting for start
// SETUP  | ss_n low, first bit on sdio_out, one half-period before first sclk edge
// SHIFT  | 24 bits, each sclk low then high for CLK_DIV cycles
// HOLD   | sclk low, one half-period before releasing ss_n
// DONE   | ss_n high, done pulse; start ignored here
module spi_master_lbus #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   spi_master_lbus_if.slave  bus,
   output logic              sclk_o,
   output logic              ss_n_o,
   output logic              sdio_out_o,
   input  logic              sdio_in_i,
   output logic              sdio_oe_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

   state_t      state_q;
   logic [7:0]  div_cnt_q;
   logic [4:0]  bit_cnt_q;
   logic [22:0] shreg_q;   // bits still to send after the current one
   logic [7:0]  rx_q;
   logic        rw_q;
   logic        sclk_q;
   logic        ss_n_q;
   logic        sdo_q;
   logic        oe_q;
   logic        busy_q;
   logic        done_q;
   logic [7:0]  rdata_q;

   logic        div_tc_d;
   assign div_tc_d = (div_cnt_q == 8'd0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         div_cnt_q <= 8'd0;
         bit_cnt_q <= 5'd0;
         shreg_q   <= 23'd0;
         rx_q      <= 8'd0;
         rw_q      <= 1'b0;
         sclk_q    <= 1'b0;
         ss_n_q    <= 1'b1;
         sdo_q     <= 1'b0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rdata_q   <= 8'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q   <= ST_SETUP;
                  rw_q      <= bus.rw;
                  shreg_q   <= {2'b00, bus.address, bus.wdata};
                  sdo_q     <= bus.rw;
                  oe_q      <= 1'b1;
                  ss_n_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  div_cnt_q <= DIV_LOAD;
                  bit_cnt_q <= 5'd0;
               end
            end
            ST_SETUP: begin
               if (div_tc_d) begin
                  state_q   <= ST_SHIFT;
                  div_cnt_q <= DIV_LOAD;
               end else begin
                  div_cnt_q <= div_cnt_q - 8'd1;
               end
            end
            ST_SHIFT: begin
               if (!div_tc_d) begin
                  div_cnt_q <= div_cnt_q - 8'd1;
               end else begin
                  div_cnt_q <= DIV_LOAD;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                  end else begin
                     // End of a high phase: last clk of the bit, so sample here.
                     sclk_q <= 1'b0;
                     if (rw_q && bit_cnt_q >= 5'd16) begin
                        rx_q <= {rx_q[6:0], sdio_in_i};
                     end
                     if (bit_cnt_q == 5'd23) begin
                        state_q <= ST_HOLD;
                        oe_q    <= 1'b0;
                        sdo_q   <= 1'b0;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        shreg_q   <= {shreg_q[21:0], 1'b0};
                        // Reads hand the line to the slave at the bit-16 low phase.
                        if (rw_q && bit_cnt_q >= 5'd15) begin
                           oe_q  <= 1'b0;
                           sdo_q <= 1'b0;
                        end else begin
                           sdo_q <= shreg_q[22];
                        end
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (div_tc_d) begin
                  state_q <= ST_DONE;
                  ss_n_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  if (rw_q) begin
                     rdata_q <= rx_q;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q - 8'd1;
               end
            end
            ST_DONE: begin
               state_q   <= ST_IDLE;
               bit_cnt_q <= 5'd0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign sclk_o     = sclk_q;
   assign ss_n_o     = ss_n_q;
   assign sdio_out_o = sdo_q;
   assign sdio_oe_o  = oe_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_spi_master_lbus.sv
// tb_spi_master_lbus
// Bench for spi_master_lbus: instance 0 uses CLK_DIV=4, instance 1 uses CLK_DIV=1.
// A slave model captures each frame on rising sclk, returns read data, and
// compares against scoreboard entries pushed when each start is driven.
module tb_spi_master_lbus;

   typedef struct {
      logic [23:0] frame;
      logic [7:0]  ret;
      logic [7:0]  rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   exp_t        exp_q [2][$];
   logic [7:0]  exp_rd [2];

   logic        start_r [2];
   logic        rw_r    [2];
   logic [12:0] addr_r  [2];
   logic [7:0]  wdata_r [2];

   logic        sclk_w [2];
   logic        ss_n_w [2];
   logic        sdo_w  [2];
   logic        oe_w   [2];
   logic        sdi_r  [2];
   logic        busy_w [2];
   logic        done_w [2];
   logic [7:0]  rdata_w [2];

   // slave-model state, written only by the monitor
   int          mon_cnt [2];
   int          last_gap [2];
   int          m_low [2];
   int          m_high [2];
   logic        m_prev_sclk [2];
   logic        m_prev_ss [2];
   logic [23:0] m_frame [2];
   logic        m_rd [2];
   logic        m_hold [2];
   logic        m_oe_bad [2];
   logic        m_zero_bad [2];
   logic [7:0]  m_ret [2];

   spi_master_lbus_if bus0 ();
   spi_master_lbus_if bus1 ();

   assign bus0.start   = start_r[0];
   assign bus0.rw      = rw_r[0];
   assign bus0.address = addr_r[0];
   assign bus0.wdata   = wdata_r[0];
   assign busy_w[0]    = bus0.busy;
   assign done_w[0]    = bus0.done;
   assign rdata_w[0]   = bus0.rdata;

   assign bus1.start   = start_r[1];
   assign bus1.rw      = rw_r[1];
   assign bus1.address = addr_r[1];
   assign bus1.wdata   = wdata_r[1];
   assign busy_w[1]    = bus1.busy;
   assign done_w[1]    = bus1.done;
   assign rdata_w[1]   = bus1.rdata;

   spi_master_lbus #(.CLK_DIV(4)) u_dut0 (
      .clk_i      (clk),
      .rst_i      (rst),
      .bus        (bus0),
      .sclk_o     (sclk_w[0]),
      .ss_n_o     (ss_n_w[0]),
      .sdio_out_o (sdo_w[0]),
      .sdio_in_i  (sdi_r[0]),
      .sdio_oe_o  (oe_w[0])
   );

   spi_master_lbus #(.CLK_DIV(1)) u_dut1 (
      .clk_i      (clk),
      .rst_i      (rst),
      .bus        (bus1),
      .sclk_o     (sclk_w[1]),
      .ss_n_o     (ss_n_w[1]),
      .sdio_out_o (sdo_w[1]),
      .sdio_in_i  (sdi_r[1]),
      .sdio_oe_o  (oe_w[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Slave model and frame checker, sampled on the falling clk edge.
   always @(negedge clk) begin
      logic rise, fall, ss_rise, exp_oe;
      exp_t e;
      for (int g = 0; g < 2; g++) begin
         if (rst) begin
            mon_cnt[g]     = 0;
            m_low[g]       = 0;
            m_high[g]      = 0;
            m_prev_sclk[g] = 1'b0;
            m_prev_ss[g]   = 1'b1;
            m_frame[g]     = 24'd0;
            m_rd[g]        = 1'b0;
            m_hold[g]      = 1'b0;
            m_oe_bad[g]    = 1'b0;
            m_zero_bad[g]  = 1'b0;
            m_ret[g]       = 8'd0;
            sdi_r[g]       = 1'b0;
         end else begin
            rise    = sclk_w[g] && !m_prev_sclk[g];
            fall    = !sclk_w[g] && m_prev_sclk[g];
            ss_rise = ss_n_w[g] && !m_prev_ss[g];
            if (!ss_n_w[g]) begin
               if (m_prev_ss[g]) begin
                  chk("frame_expected", 32'(exp_q[g].size() > 0), 32'd1);
                  last_gap[g]   = m_high[g];
                  mon_cnt[g]    = 0;
                  m_low[g]      = 0;
                  m_frame[g]    = 24'd0;
                  m_rd[g]       = 1'b0;
                  m_hold[g]     = 1'b0;
                  m_oe_bad[g]   = 1'b0;
                  m_zero_bad[g] = 1'b0;
                  m_ret[g]      = (exp_q[g].size() > 0) ? exp_q[g][0].ret : 8'd0;
               end
               m_low[g]++;
               if (rise) begin
                  m_frame[g] = {m_frame[g][22:0], sdo_w[g]};
                  mon_cnt[g]++;
                  if (mon_cnt[g] == 1) m_rd[g] = sdo_w[g];
               end
               if (fall && mon_cnt[g] == 24) m_hold[g] = 1'b1;
               if (m_hold[g])
                  exp_oe = 1'b0;
               else if (m_rd[g] && (mon_cnt[g] > 16 || (mon_cnt[g] == 16 && !sclk_w[g])))
                  exp_oe = 1'b0;
               else
                  exp_oe = 1'b1;
               if (oe_w[g] !== exp_oe) m_oe_bad[g] = 1'b1;
               if (!oe_w[g] && sdo_w[g]) m_zero_bad[g] = 1'b1;
               if (m_rd[g] && sclk_w[g] && mon_cnt[g] >= 17 && mon_cnt[g] <= 24)
                  sdi_r[g] = m_ret[g][24 - mon_cnt[g]];
               else
                  sdi_r[g] = 1'b0;
            end else begin
               if (!m_prev_ss[g]) m_high[g] = 0;
               m_high[g]++;
               sdi_r[g] = 1'b0;
               if (!oe_w[g] && sdo_w[g]) m_zero_bad[g] = 1'b1;
            end
            if (ss_rise || done_w[g]) begin
               chk("done_with_ss_rise", 32'(done_w[g]), 32'(ss_rise));
            end
            if (done_w[g]) begin
               chk("busy_at_done", 32'(busy_w[g]), 32'd0);
               chk("done_has_entry", 32'(exp_q[g].size() > 0), 32'd1);
               if (exp_q[g].size() > 0) begin
                  e = exp_q[g].pop_front();
                  chk("frame", 32'(m_frame[g]), 32'(e.frame));
                  chk("bit_count", 32'(mon_cnt[g]), 32'd24);
                  chk("ss_low_cycles", 32'(m_low[g]), (g == 0) ? 32'd200 : 32'd50);
                  chk("rdata", 32'(rdata_w[g]), 32'(e.rdata));
                  chk("oe_pattern", 32'(m_oe_bad[g]), 32'd0);
                  chk("sdo_zero_when_released", 32'(m_zero_bad[g]), 32'd0);
               end
            end
            m_prev_sclk[g] = sclk_w[g];
            m_prev_ss[g]   = ss_n_w[g];
         end
      end
   end

   task automatic txn(input int g, input logic rw, input logic [12:0] a,
                      input logic [7:0] wd, input logic [7:0] ret);
      exp_t e;
      int   t;
      t = 0;
      while ((busy_w[g] || done_w[g]) && t < 2000) begin
         step();
         t++;
      end
      chk("idle_wait", 32'(t < 2000), 32'd1);
      if (rw) exp_rd[g] = ret;
      e.frame = {rw, 2'b00, a, (rw ? 8'h00 : wd)};
      e.ret   = ret;
      e.rdata = exp_rd[g];
      exp_q[g].push_back(e);
      start_r[g] = 1'b1;
      rw_r[g]    = rw;
      addr_r[g]  = a;
      wdata_r[g] = wd;
      step();
      start_r[g] = 1'b0;
      rw_r[g]    = 1'($urandom);
      addr_r[g]  = 13'($urandom);
      wdata_r[g] = 8'($urandom);
      chk("busy_after_start", 32'(busy_w[g]), 32'd1);
   endtask

   task automatic wait_done(input int g);
      int t;
      t = 0;
      while (exp_q[g].size() > 0 && t < 5000) begin
         step();
         t++;
      end
      chk("done_wait", 32'(exp_q[g].size()), 32'd0);
   endtask

   initial begin
      exp_t e;
      int   acc, t;
      logic prev_busy;
      for (int g = 0; g < 2; g++) begin
         start_r[g] = 1'b0;
         rw_r[g]    = 1'b0;
         addr_r[g]  = 13'd0;
         wdata_r[g] = 8'd0;
         exp_rd[g]  = 8'd0;
      end
      repeat (3) step();
      for (int g = 0; g < 2; g++) begin
         chk("rst_ss_n", 32'(ss_n_w[g]), 32'd1);
         chk("rst_sclk", 32'(sclk_w[g]), 32'd0);
         chk("rst_oe", 32'(oe_w[g]), 32'd0);
         chk("rst_sdo", 32'(sdo_w[g]), 32'd0);
         chk("rst_busy", 32'(busy_w[g]), 32'd0);
         chk("rst_done", 32'(done_w[g]), 32'd0);
         chk("rst_rdata", 32'(rdata_w[g]), 32'd0);
      end
      rst = 1'b0;
      repeat (2) step();

      // write 0x0008 / 0x03
      txn(0, 1'b0, 13'h0008, 8'h03, 8'h00);
      wait_done(0);

      // read 0x0001, slave returns 0x82
      txn(0, 1'b1, 13'h0001, 8'h00, 8'h82);
      wait_done(0);

      // start pulsed mid-frame with different inputs
      txn(0, 1'b1, 13'h1234, 8'h00, 8'h3C);
      repeat (60) step();
      start_r[0] = 1'b1;
      rw_r[0]    = 1'b0;
      addr_r[0]  = 13'h1FFF;
      wdata_r[0] = 8'hFF;
      step();
      start_r[0] = 1'b0;
      wait_done(0);
      repeat (30) step();
      chk("no_second_frame_ss", 32'(ss_n_w[0]), 32'd1);
      chk("no_second_frame_busy", 32'(busy_w[0]), 32'd0);

      // random mix
      for (int i = 0; i < 4; i++) begin
         txn(0, 1'($urandom_range(0, 1)), 13'($urandom), 8'($urandom), 8'($urandom));
         wait_done(0);
      end

      // reset at bit 10 of a read
      txn(0, 1'b1, 13'h0055, 8'h00, 8'hE7);
      t = 0;
      while (mon_cnt[0] < 11 && t < 2000) begin
         step();
         t++;
      end
      chk("reach_bit10", 32'(mon_cnt[0]), 32'd11);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_ss_n", 32'(ss_n_w[0]), 32'd1);
      chk("midrst_sclk", 32'(sclk_w[0]), 32'd0);
      chk("midrst_oe", 32'(oe_w[0]), 32'd0);
      chk("midrst_sdo", 32'(sdo_w[0]), 32'd0);
      chk("midrst_busy", 32'(busy_w[0]), 32'd0);
      chk("midrst_rdata", 32'(rdata_w[0]), 32'd0);
      exp_q[0].delete();
      exp_rd[0] = 8'd0;
      exp_rd[1] = 8'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("midrst_no_done", 32'(done_w[0]), 32'd0);
      end
      rst = 1'b0;
      repeat (250) step();
      chk("postrst_rdata", 32'(rdata_w[0]), 32'd0);
      chk("postrst_ss_n", 32'(ss_n_w[0]), 32'd1);

      // CLK_DIV=1: read, write (rdata must hold), read
      txn(1, 1'b1, 13'h1ABC, 8'h00, 8'h5A);
      wait_done(1);
      txn(1, 1'b0, 13'h0007, 8'h99, 8'h00);
      wait_done(1);
      chk("div1_write_keeps_rdata", 32'(rdata_w[1]), 32'h5A);
      txn(1, 1'b1, 13'h0100, 8'h00, 8'hC3);
      wait_done(1);

      // start held high: back-to-back frames one IDLE cycle after each done
      for (int i = 0; i < 3; i++) begin
         e.frame = {1'b0, 2'b00, 13'h0F0F, 8'hA5};
         e.ret   = 8'h00;
         e.rdata = exp_rd[0];
         exp_q[0].push_back(e);
      end
      start_r[0] = 1'b1;
      rw_r[0]    = 1'b0;
      addr_r[0]  = 13'h0F0F;
      wdata_r[0] = 8'hA5;
      acc = 0;
      t = 0;
      prev_busy = busy_w[0];
      while (acc < 3 && t < 3000) begin
         step();
         t++;
         if (busy_w[0] && !prev_busy) begin
            acc++;
            if (acc > 1) chk("held_gap", 32'(last_gap[0]), 32'd2);
         end
         prev_busy = busy_w[0];
      end
      start_r[0] = 1'b0;
      chk("held_accepts", 32'(acc), 32'd3);
      wait_done(0);
      repeat (20) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_master_lbus.md
SPI_MASTER_LBUS -- requirements
Module: spi_master_lbus

Interface
REQ-001 Parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request; accepted only while busy=0.
REQ-005 rw  input  1  1=read, 0=write; sampled with start.
REQ-006 address  input  13  register address A12..A0; sampled with start.
REQ-007 wdata  input  8  write byte; sampled with start.
REQ-008 busy  output  1  high from the cycle after start is accepted until the cycle done pulses.
REQ-009 done  output  1  one-cycle pulse at transaction end.
REQ-010 rdata  output  8  last byte read; held until the next read completes.
REQ-011 sclk  output  1  SPI clock; idles low.
REQ-012 ss_n  output  1  SPI chip select, active low; idles high.
REQ-013 sdio_out  output  1  serial data driven toward the shared sdio line.
REQ-014 sdio_in  input  1  serial data sampled from the shared sdio line.
REQ-015 sdio_oe  output  1  1=master drives sdio, 0=line released to slave.

Function
REQ-016 Frame SHALL be 24 bits, MSB first: instruction {rw, W1W0=2'b00, address[12:0]} followed by one data byte.
REQ-017 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, DONE; IDLE->SETUP on accepted start; SETUP->SHIFT after CLK_DIV cycles; SHIFT->HOLD after the 24th sclk high phase; HOLD->DONE after CLK_DIV cycles; DONE->IDLE after one cycle.
REQ-018 ss_n SHALL go low on entry to SETUP and return high on entry to DONE.
REQ-019 Each bit SHALL take 2*CLK_DIV cycles: sclk low for CLK_DIV, then high for CLK_DIV; a 5-bit counter tracks bits 0..23.
REQ-020 sdio_out SHALL update at the start of each low phase; the slave samples on the rising sclk edge.
REQ-021 sdio_oe SHALL be 1 from SETUP through bit 15 for reads, and through bit 23 for writes; 0 otherwise.
REQ-022 For reads, sdio_oe SHALL drop at the start of the bit-16 low phase, the turnaround edge.
REQ-023 For reads, sdio_in SHALL be sampled on the last clk of each high phase of bits 16..23.
REQ-024 rdata SHALL load the assembled byte on entry to DONE for reads only; writes leave rdata unchanged.
REQ-025 sdio_out SHALL be 0 whenever sdio_oe=0.
REQ-026 ss_n low duration SHALL be exactly 50*CLK_DIV cycles (SETUP + 48 phases + HOLD).
REQ-027 done SHALL assert in the cycle ss_n rises; busy deasserts in that same cycle.
REQ-028 start while busy=1 SHALL be ignored, with no latch of rw, address or wdata.
REQ-029 start asserted in the DONE cycle SHALL be ignored; the earliest accepted start is the following IDLE cycle.
REQ-030 Inputs SHALL be latched at acceptance; later changes to them do not affect the frame in progress.

Reset
REQ-031 While reset=1, and immediately on its assertion including mid-frame: ss_n=1, sclk=0, sdio_oe=0, sdio_out=0, busy=0, done=0, rdata=8'h00, state=IDLE, bit counter=0.
REQ-032 A frame interrupted by reset SHALL NOT pulse done or update rdata.

Verification
REQ-033 Write, CLK_DIV=4, address=13'h008, wdata=8'h03 -> stream on rising sclk edges 0x0008 then 0x03; ss_n low 200 cycles; sdio_oe=1 throughout; done pulses once.
REQ-034 Read, address=13'h001, slave model returns 8'h82 -> instruction 0x8001; sdio_oe falls at start of bit-16 low phase; rdata=8'h82 at done.
REQ-035 start pulsed mid-frame with different inputs -> frame unchanged; no second transaction begins.
REQ-036 reset asserted at bit 10 of a read -> same cycle: ss_n=1, sclk=0, sdio_oe=0; no done; rdata=8'h00.
REQ-037 CLK_DIV=1, write then read -> ss_n low 50 cycles each; write does not alter rdata from its prior value.
REQ-038 start held high continuously -> new frames start one IDLE cycle after each done; ss_n high at least 2 cycles between frames.
